// File: rtl/instr_exec_sequencer.sv
// ---------------------------------------------------------------------------
// instr_exec_sequencer
//
// Purpose:
//   This block walks a run of instruction words held in an external
//   instruction register. It starts at base_ptr and executes count words.
//   Each word passes through FETCH (operands are captured), EXEC (the result
//   is computed and registered) and OUTPUT (the result is held until the
//   consumer accepts it). With result_ready held high, one result comes out
//   every 3 cycles.
//
// Ports:
//   clk           sole clock, rising edge
//   reset_n       asynchronous active-low reset
//   start         run request, sampled only in IDLE
//   base_ptr      first instruction-register address of the run
//   count         number of words to execute (0 .. 2**ADDR_W)
//   read_pointer  address presented to the instruction register
//   iw_opcode     opcode of the addressed word (combinational read)
//   iw_operand_a  signed operand a of the addressed word
//   iw_operand_b  signed operand b of the addressed word
//   result        signed execution result
//   result_ptr    address the current result came from
//   result_valid  result handshake valid
//   result_ready  result handshake ready
//   busy          high from the accepted start until done
//   done          one-cycle pulse when a run completes
//   err           sticky per run: zero divisor or illegal opcode seen
//
// Configuration macro:
//   INSTR_EXEC_SAT_EN  when defined, ADD/SUB/MULT/DIV saturate to the signed
//                      32-bit range. Otherwise they wrap (two's complement).
// ---------------------------------------------------------------------------
module instr_exec_sequencer #(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_ptr,
    input  logic [ADDR_W:0]   count,
    output logic [ADDR_W-1:0] read_pointer,
    input  logic [3:0]        iw_opcode,
    input  logic [31:0]       iw_operand_a,
    input  logic [31:0]       iw_operand_b,
    output logic [31:0]       result,
    output logic [ADDR_W-1:0] result_ptr,
    output logic              result_valid,
    input  logic              result_ready,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int DATA_W = 32;

    localparam logic [3:0] OP_ZERO  = 4'd0;
    localparam logic [3:0] OP_PASSA = 4'd1;
    localparam logic [3:0] OP_PASSB = 4'd2;
    localparam logic [3:0] OP_ADD   = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd4;
    localparam logic [3:0] OP_MULT  = 4'd5;
    localparam logic [3:0] OP_DIV   = 4'd6;
    localparam logic [3:0] OP_MOD   = 4'd7;

    localparam logic signed [63:0] MAX64 = 64'sd2147483647;
    localparam logic signed [63:0] MIN64 = -64'sd2147483648;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        EXEC   = 3'd2,
        OUTPUT = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_W:0] remaining;

    // Captured instruction word (FETCH -> EXEC)
    logic        [3:0]        op_p0;
    logic signed [DATA_W-1:0] opa_p0;
    logic signed [DATA_W-1:0] opb_p0;

    // EXEC combinational results
    logic signed [DATA_W-1:0] exec_res;
    logic                     exec_err;
    logic signed [63:0]       a64;
    logic signed [63:0]       b64;
    logic signed [63:0]       div_b64;
    logic signed [63:0]       quo64;
    logic signed [63:0]       rem64;

    logic run_start;
    logic zero_start;
    logic handshake;
    logic last_word;

    // Reduces an exact 64-bit result to 32 bits. It either clamps to the
    // signed 32-bit range or keeps the low word.
    function automatic logic signed [DATA_W-1:0] fit32(input logic signed [63:0] v);
`ifdef INSTR_EXEC_SAT_EN
        if (v > MAX64) begin
            return 32'sh7fffffff;
        end else if (v < MIN64) begin
            return 32'sh80000000;
        end else begin
            return 32'(v);
        end
`else
        return 32'(v);
`endif
    endfunction

    assign run_start  = (state == IDLE) && start && (count != '0);
    assign zero_start = (state == IDLE) && start && (count == '0);
    assign handshake  = (state == OUTPUT) && result_ready;
    // The decrement lands on the same edge, so "last" means one word left.
    assign last_word  = (remaining == (ADDR_W+1)'(1));

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (run_start) begin
                    state_nxt = FETCH;
                end else if (zero_start) begin
                    state_nxt = DONE;
                end
            end
            FETCH:  state_nxt = EXEC;
            EXEC:   state_nxt = OUTPUT;
            OUTPUT: begin
                if (handshake) begin
                    state_nxt = last_word ? DONE : FETCH;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- state-decoded outputs ----------------
    always_comb begin
        busy         = 1'b0;
        done         = 1'b0;
        result_valid = 1'b0;
        case (state)
            FETCH:  busy = 1'b1;
            EXEC:   busy = 1'b1;
            OUTPUT: begin
                busy         = 1'b1;
                result_valid = 1'b1;
            end
            DONE:   done = 1'b1;
            default: begin
                busy         = 1'b0;
                done         = 1'b0;
                result_valid = 1'b0;
            end
        endcase
    end

    // ---------------- stage p0: capture word in FETCH ----------------
    always_ff @(posedge clk) begin
        if (state == FETCH) begin
            op_p0  <= iw_opcode;
            opa_p0 <= iw_operand_a;
            opb_p0 <= iw_operand_b;
        end
    end

    // ---------------- EXEC: arithmetic on the captured word ----------------
    always_comb begin
        a64 = {{32{opa_p0[31]}}, opa_p0};
        b64 = {{32{opb_p0[31]}}, opb_p0};
        // Keeps the divider defined when b is zero. That result is discarded anyway.
        div_b64 = (opb_p0 == '0) ? 64'sd1 : b64;
        // Evaluated at 64 bits so -2**31 / -1 yields +2**31 before reduction.
        quo64 = a64 / div_b64;
        rem64 = a64 % div_b64;

        exec_res = '0;
        exec_err = 1'b0;
        case (op_p0)
            OP_ZERO:  exec_res = '0;
            OP_PASSA: exec_res = opa_p0;
            OP_PASSB: exec_res = opb_p0;
            OP_ADD:   exec_res = fit32(a64 + b64);
            OP_SUB:   exec_res = fit32(a64 - b64);
            OP_MULT:  exec_res = fit32(a64 * b64);
            OP_DIV: begin
                if (opb_p0 == '0) begin
                    exec_err = 1'b1;
                end else begin
                    exec_res = fit32(quo64);
                end
            end
            OP_MOD: begin
                if (opb_p0 == '0) begin
                    exec_err = 1'b1;
                end else begin
                    exec_res = 32'(rem64);
                end
            end
            default: exec_err = 1'b1;
        endcase
    end

    // ---------------- stage p1: result and run bookkeeping ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            read_pointer <= '0;
            remaining    <= '0;
            result       <= '0;
            result_ptr   <= '0;
            err          <= 1'b0;
        end else begin
            if (run_start) begin
                read_pointer <= base_ptr;
                remaining    <= count;
                err          <= 1'b0;
            end
            if (state == EXEC) begin
                result     <= exec_res;
                result_ptr <= read_pointer;
                if (exec_err) begin
                    err <= 1'b1;
                end
            end
            // The pointer is ADDR_W bits wide, so the top address wraps to 0.
            if (handshake) begin
                remaining    <= remaining - 1'b1;
                read_pointer <= read_pointer + 1'b1;
            end
        end
    end

endmodule
